// File: rtl/pixel_spike_encoder_pkg.sv
// Shared types, FSM state codes and LFSR feedback masks for the pixel spike encoder.
package pixel_spike_encoder_pkg;

    typedef enum logic {
        ENC_RATE = 1'b0,
        ENC_TTFS = 1'b1
    } enc_mode_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SCAN = 3'd2;
    localparam logic [2:0] ST_REQ  = 3'd3;
    localparam logic [2:0] ST_REL  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // Right-shifting Galois masks that give a maximal-length sequence for each width.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            2:       lfsr_taps = 32'h0000_0003;
            3:       lfsr_taps = 32'h0000_0006;
            4:       lfsr_taps = 32'h0000_000C;
            5:       lfsr_taps = 32'h0000_0014;
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0E08;
            13:      lfsr_taps = 32'h0000_1C80;
            14:      lfsr_taps = 32'h0000_3802;
            15:      lfsr_taps = 32'h0000_6000;
            16:      lfsr_taps = 32'h0000_D008;
            default: lfsr_taps = 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/pixel_spike_encoder_lfsr.sv
// Galois LFSR supplying the rate-coding threshold; never reaches zero because the seed is nonzero.
module spike_lfsr
    import pixel_spike_encoder_pkg::*;
#(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   SEED  = WIDTH'(8'hA5)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    localparam logic [31:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (enable) begin
            value <= value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
        end
    end

endmodule

// File: rtl/pixel_spike_encoder.sv
// Replays one stored grayscale image as 4-phase AER events over TIMESTEPS steps,
// using either LFSR rate coding or time-to-first-spike coding.
module pixel_spike_encoder
    import pixel_spike_encoder_pkg::*;
#(
    parameter int                    IMAGE_SIZE = 256,
    parameter int                    PIXEL_BITS = 8,
    parameter int                    N          = 256,
    parameter int                    TIMESTEPS  = 16,
    parameter logic [PIXEL_BITS-1:0] LFSR_SEED  = PIXEL_BITS'(8'hA5)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_mode,
    input  logic                         start,
    input  logic                         pix_valid,
    input  logic [PIXEL_BITS-1:0]        pix_data,
    output logic                         pix_ready,
    output logic                         aer_req,
    output logic [$clog2(N)-1:0]         aer_addr,
    input  logic                         aer_ack,
    output logic [$clog2(TIMESTEPS)-1:0] ts,
    output logic                         busy,
    output logic                         done
);

    localparam int                    TS_BITS    = $clog2(TIMESTEPS);
    localparam int                    ADDR_BITS  = $clog2(N);
    localparam int                    TTFS_SHIFT = PIXEL_BITS - TS_BITS;
    localparam logic [PIXEL_BITS-1:0] MAXPIX     = '1;
    localparam logic [ADDR_BITS-1:0]  LAST_IDX   = ADDR_BITS'(IMAGE_SIZE - 1);
    localparam logic [TS_BITS-1:0]    LAST_TS    = TS_BITS'(TIMESTEPS - 1);

    logic [2:0]            state, state_n;
    logic [ADDR_BITS-1:0]  idx, idx_n;
    logic [TS_BITS-1:0]    ts_n;
    logic [ADDR_BITS-1:0]  addr_n;
    enc_mode_t             mode, mode_n;

    logic [PIXEL_BITS-1:0] mem [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0] rd_data;
    logic [PIXEL_BITS-1:0] lfsr_val;
    logic [PIXEL_BITS-1:0] ttfs_target;
    logic                  wr_en;
    logic                  lfsr_load;
    logic                  lfsr_step;
    logic                  advance;
    logic                  spike;

    spike_lfsr #(
        .WIDTH (PIXEL_BITS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .enable (lfsr_step),
        .value  (lfsr_val)
    );

    assign ttfs_target = (MAXPIX - rd_data) >> TTFS_SHIFT;

    always_comb begin
        if (mode == ENC_TTFS) begin
            spike = (rd_data != '0) && (ttfs_target == PIXEL_BITS'(ts));
        end else begin
            spike = (lfsr_val <= rd_data);
        end
    end

    // A spike is held back while a stale ACK is still high so REQ never rises onto ACK=1.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        ts_n      = ts;
        addr_n    = aer_addr;
        mode_n    = mode;
        wr_en     = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n   = ST_LOAD;
                    idx_n     = '0;
                    mode_n    = enc_mode_t'(cfg_mode);
                    lfsr_load = 1'b1;
                end else if (state == ST_DONE) begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (pix_valid) begin
                    wr_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = ST_SCAN;
                        idx_n   = '0;
                        ts_n    = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (!spike) begin
                    lfsr_step = 1'b1;
                    advance   = 1'b1;
                end else if (!aer_ack) begin
                    lfsr_step = 1'b1;
                    state_n   = ST_REQ;
                    addr_n    = idx;
                end
            end
            ST_REQ: begin
                if (aer_ack) begin
                    state_n = ST_REL;
                end
            end
            ST_REL: begin
                if (!aer_ack) begin
                    advance = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (advance) begin
            if (idx == LAST_IDX) begin
                idx_n = '0;
                if (ts == LAST_TS) begin
                    state_n = ST_DONE;
                end else begin
                    ts_n    = ts + 1'b1;
                    state_n = ST_SCAN;
                end
            end else begin
                idx_n   = idx + 1'b1;
                state_n = ST_SCAN;
            end
        end
    end

    // REQ comes straight from a flop so the core never sees a decode glitch on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            ts       <= '0;
            aer_addr <= '0;
            mode     <= ENC_RATE;
            aer_req  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            ts       <= ts_n;
            aer_addr <= addr_n;
            mode     <= mode_n;
            aer_req  <= (state_n == ST_REQ);
        end
    end

    // Reading at the next index keeps rd_data aligned with idx, so SCAN sustains one pixel per cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= pix_data;
        end
        rd_data <= mem[idx_n];
    end

    assign pix_ready = (state == ST_LOAD);
    assign busy      = (state == ST_LOAD) || (state == ST_SCAN) ||
                       (state == ST_REQ)  || (state == ST_REL);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_pixel_spike_encoder.sv
// Directed self-checking bench for pixel_spike_encoder: a 2-cycle-latency AER core model
// records every event, and each run is compared with hand-derived or LFSR-model golden lists.
module tb_pixel_spike_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_mode = 1'b0;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;
    logic       pix_ready;
    logic       aer_req;
    logic [7:0] aer_addr;
    logic       aer_ack = 1'b0;
    logic [3:0] ts;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    logic [7:0]  img [256];
    logic [11:0] ev_q [$];
    logic [11:0] exp_q [$];
    int          done_cnt = 0;
    int          addr_glitch = 0;
    int          ack_wait = 0;
    logic        ack_en = 1'b1;
    logic        req_prev = 1'b0;
    logic [7:0]  held_addr = 8'd0;

    pixel_spike_encoder #(
        .IMAGE_SIZE (256),
        .PIXEL_BITS (8),
        .N          (256),
        .TIMESTEPS  (16),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .aer_req   (aer_req),
        .aer_addr  (aer_addr),
        .aer_ack   (aer_ack),
        .ts        (ts),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Core model: logs each REQ rising edge as {ts, addr} and answers with ACK two cycles later.
    always @(negedge clk) begin
        if (rst) begin
            aer_ack  = 1'b0;
            ack_wait = 0;
            req_prev = 1'b0;
        end else begin
            if (aer_req && !req_prev) begin
                ev_q.push_back({ts, aer_addr});
            end
            if (aer_req && req_prev && (aer_addr !== held_addr)) begin
                addr_glitch++;
            end
            held_addr = aer_addr;
            req_prev  = aer_req;
            if (done) begin
                done_cnt++;
            end
            if (aer_req && !aer_ack) begin
                if (ack_en) begin
                    ack_wait++;
                    if (ack_wait >= 2) begin
                        aer_ack = 1'b1;
                    end
                end
            end else if (!aer_req) begin
                aer_ack  = 1'b0;
                ack_wait = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic load_image(input logic mode);
        @(negedge clk);
        cfg_mode = mode;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_ready", 32'(pix_ready), 32'd1);
        for (int i = 0; i < 256; i++) begin
            pix_valid = 1'b1;
            pix_data  = img[i];
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        check("load_exit_ready", 32'(pix_ready), 32'd0);
        check("scan_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic compare_events(input string tag, input int base);
        int errs;
        int n;
        errs = 0;
        n = ev_q.size() - base;
        check({tag, "_event_count"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            if (ev_q[base + i] !== exp_q[i]) begin
                errs++;
            end
        end
        check({tag, "_event_list_errs"}, 32'(errs), 32'd0);
    endtask

    initial begin
        int base;
        int dbase;
        int cycles;
        int n;
        logic [7:0] lf;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", 32'(aer_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(pix_ready), 32'd0);
        check("rst_ts", 32'(ts), 32'd0);
        check("rst_addr", 32'(aer_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        pix_valid = 1'b1;
        @(negedge clk);
        check("idle_valid_ready", 32'(pix_ready), 32'd0);
        check("idle_valid_busy", 32'(busy), 32'd0);
        pix_valid = 1'b0;

        // Rate, all pixels max: every pixel spikes every step
        $display("[TB] rate, all pixels 255");
        for (int i = 0; i < 256; i++) img[i] = 8'd255;
        exp_q.delete();
        for (int k = 0; k < 4096; k++) exp_q.push_back(12'(k));
        base  = ev_q.size();
        dbase = done_cnt;
        load_image(1'b0);
        wait_done("rate255", 30000, cycles);
        repeat (4) @(negedge clk);
        compare_events("rate255", base);
        check("rate255_done_pulses", 32'(done_cnt - dbase), 32'd1);
        check("rate255_idle_busy", 32'(busy), 32'd0);

        // Rate, all pixels zero: no events, one pixel per cycle
        $display("[TB] rate, all pixels 0");
        for (int i = 0; i < 256; i++) img[i] = 8'd0;
        exp_q.delete();
        base  = ev_q.size();
        dbase = done_cnt;
        load_image(1'b0);
        wait_done("rate0", 6000, cycles);
        check("rate0_latency_ok", 32'((cycles >= 4096) && (cycles <= 4100)), 32'd1);
        repeat (4) @(negedge clk);
        compare_events("rate0", base);
        check("rate0_done_pulses", 32'(done_cnt - dbase), 32'd1);

        // Reset while REQ waits for ACK
        $display("[TB] reset during handshake");
        for (int i = 0; i < 256; i++) img[i] = 8'd255;
        load_image(1'b0);
        n = 0;
        while (ts != 4'd1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("hs_reached_ts1", 32'(ts), 32'd1);
        ack_en = 1'b0;
        n = 0;
        while (!(aer_req && !aer_ack) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hs_req_pending", 32'(aer_req), 32'd1);
        rst = 1'b1;
        #1;
        check("hs_rst_req", 32'(aer_req), 32'd0);
        check("hs_rst_busy", 32'(busy), 32'd0);
        check("hs_rst_ts", 32'(ts), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);

        // TTFS: px[3]=255 fires at step 0, px[7]=16 fires at step (239>>4)=14
        $display("[TB] TTFS, two nonzero pixels");
        for (int i = 0; i < 256; i++) img[i] = 8'd0;
        img[3] = 8'd255;
        img[7] = 8'd16;
        exp_q.delete();
        exp_q.push_back({4'd0, 8'd3});
        exp_q.push_back({4'd14, 8'd7});
        base  = ev_q.size();
        dbase = done_cnt;
        load_image(1'b1);
        wait_done("ttfs", 6000, cycles);
        repeat (4) @(negedge clk);
        compare_events("ttfs", base);
        check("ttfs_done_pulses", 32'(done_cnt - dbase), 32'd1);

        // Rate, px=128 against an LFSR golden model, with START/PIX_VALID/CFG_MODE noise mid-scan
        $display("[TB] rate, all pixels 128 with mid-scan noise");
        for (int i = 0; i < 256; i++) img[i] = 8'd128;
        exp_q.delete();
        lf = 8'hA5;
        for (int k = 0; k < 4096; k++) begin
            if (lf <= 8'd128) exp_q.push_back(12'(k));
            lf = lf[0] ? ((lf >> 1) ^ 8'hB8) : (lf >> 1);
        end
        base  = ev_q.size();
        dbase = done_cnt;
        load_image(1'b0);
        repeat (100) @(negedge clk);
        start     = 1'b1;
        cfg_mode  = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("noise_ready", 32'(pix_ready), 32'd0);
        check("noise_busy", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        pix_valid = 1'b0;
        cfg_mode  = 1'b0;
        wait_done("rate128", 30000, cycles);
        repeat (4) @(negedge clk);
        compare_events("rate128", base);
        n = ev_q.size() - base;
        check("rate128_density_ok", 32'((n > 1900) && (n < 2200)), 32'd1);
        check("rate128_done_pulses", 32'(done_cnt - dbase), 32'd1);
        check("addr_stable_during_req", 32'(addr_glitch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
